// File: rtl/des_pkg.sv
// ----------------------------------------------------------------------------
// des_pkg : shared widths, IP/FP tables, permutation helpers and FSM encoding
//           for the iterative DES controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package des_pkg;

  localparam int W32 = 32;
  localparam int W48 = 48;
  localparam int W64 = 64;

  // Element [j] holds the 1-based DES source position for output vector bit j
  // (bit 63 = DES bit 1), so the first listed entry is output DES bit 1.
  typedef logic [63:0][6:0] perm_tbl_t;

  localparam perm_tbl_t IP_TBL = {
    7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
    7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
    7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
    7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
    7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
    7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
  };

  localparam perm_tbl_t FP_TBL = {
    7'd40, 7'd8, 7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
    7'd39, 7'd7, 7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
    7'd38, 7'd6, 7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
    7'd37, 7'd5, 7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
    7'd36, 7'd4, 7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
    7'd35, 7'd3, 7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
    7'd34, 7'd2, 7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
    7'd33, 7'd1, 7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [63:0] des_permute(input logic [63:0] d, input perm_tbl_t t);
    logic [63:0] r;
    logic [6:0]  s;
    r = '0;
    for (int j = 0; j < 64; j++) begin
      s = 7'd64 - t[j[5:0]];
      r[j[5:0]] = d[s[5:0]];
    end
    return r;
  endfunction

  function automatic logic [63:0] des_ip(input logic [63:0] d);
    return des_permute(d, IP_TBL);
  endfunction

  function automatic logic [63:0] des_fp(input logic [63:0] d);
    return des_permute(d, FP_TBL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_perm64.sv
// ----------------------------------------------------------------------------
// des_perm64 : combinational 64-bit bit permutation selected by a table parameter.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module des_perm64
  import des_pkg::*;
#(
  parameter perm_tbl_t TABLE = IP_TBL
) (
  input  logic [W64-1:0] din,
  output logic [W64-1:0] dout
);

  for (genvar j = 0; j < W64; j++) begin : g_bit
    localparam logic [6:0] SRC = 7'd64 - TABLE[j];
    assign dout[j] = din[SRC[5:0]];
  end

endmodule

`default_nettype wire

// File: rtl/des_iter_ctrl.sv
// ----------------------------------------------------------------------------
// des_iter_ctrl : sequences an external shared Round f-function through the
//                 Feistel rounds of one DES block, with IP/FP and handshakes.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module des_iter_ctrl
  import des_pkg::*;
#(
  parameter int F_LAT   = 1,
  parameter int NROUNDS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W64-1:0] in_data,
  input  logic           in_decrypt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W64-1:0] out_data,
  output logic           busy,
  output logic [3:0]     ks_idx,
  input  logic [W48-1:0] ks_subkey,
  output logic [W32-1:0] f_r_dat,
  output logic [W48-1:0] f_key_dat,
  input  logic [W32-1:0] f_out
);

  localparam logic [2:0] WC_LAST  = 3'(F_LAT);
  localparam logic [3:0] RND_LAST = 4'(NROUNDS - 1);

  state_t         state;
  state_t         state_nx;
  logic [W32-1:0] l_q;
  logic [W32-1:0] r_q;
  logic           dec_q;
  logic [3:0]     rnd_q;
  logic [2:0]     wcnt_q;
  logic [W64-1:0] ip_out;
  logic [W64-1:0] fp_out;
  logic           accept;
  logic           round_end;
  logic           last_round;

  des_perm64 #(.TABLE(IP_TBL)) u_ip (
    .din  (in_data),
    .dout (ip_out)
  );

  // FP sees the swapped preoutput R16||L16 of the round being completed.
  des_perm64 #(.TABLE(FP_TBL)) u_fp (
    .din  ({l_q ^ f_out, r_q}),
    .dout (fp_out)
  );

  assign accept     = (state == ST_IDLE) && in_valid;
  assign round_end  = (state == ST_RUN) && (wcnt_q == WC_LAST);
  assign last_round = round_end && (rnd_q == RND_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    ks_idx    = 4'd0;
    f_r_dat   = '0;
    f_key_dat = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_RUN;
      end
      ST_RUN: begin
        busy      = 1'b1;
        ks_idx    = dec_q ? (4'd15 - rnd_q) : rnd_q;
        f_r_dat   = r_q;
        f_key_dat = ks_subkey;
        if (last_round) state_nx = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_q      <= '0;
      r_q      <= '0;
      dec_q    <= 1'b0;
      rnd_q    <= 4'd0;
      wcnt_q   <= 3'd0;
      out_data <= '0;
    end else if (accept) begin
      {l_q, r_q} <= ip_out;
      dec_q      <= in_decrypt;
      rnd_q      <= 4'd0;
      wcnt_q     <= 3'd0;
    end else if (state == ST_RUN) begin
      if (round_end) begin
        l_q    <= r_q;
        r_q    <= l_q ^ f_out;
        wcnt_q <= 3'd0;
        rnd_q  <= rnd_q + 4'd1;
        if (last_round) out_data <= fp_out;
      end else begin
        wcnt_q <= wcnt_q + 3'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_des_iter_ctrl.sv
// ----------------------------------------------------------------------------
// tb_des_iter_ctrl : bench for des_iter_ctrl with behavioural Round and key
//                    schedule models, known-answer vectors and handshake cases.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_des_iter_ctrl;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] PT = 64'h0123456789ABCDEF;
  localparam logic [63:0] CT = 64'h85E813540F0AB405;

  localparam int E_T [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [3:0] SBOX [512] = '{
    14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
    0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
    4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
    15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13,
    15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
    3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
    0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
    13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9,
    10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
    13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
    1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12,
    7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
    13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
    10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
    3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14,
    2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
    14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
    4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
    11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3,
    12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
    10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
    9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
    4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13,
    4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
    13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
    1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
    6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12,
    13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
    1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
    7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
    2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11};

  typedef struct {
    logic [63:0] key;
    logic [63:0] din;
    logic        dec;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_decrypt, out_valid, out_ready, busy;
  logic [63:0] in_data, out_data;
  logic [3:0]  ks_idx;
  logic [47:0] ks_subkey, f_key_dat;
  logic [31:0] f_r_dat, f_out, f_pipe;

  logic        s3_in_valid, s3_in_ready, s3_in_decrypt, s3_out_valid, s3_out_ready, s3_busy;
  logic [63:0] s3_in_data, s3_out_data;
  logic [3:0]  s3_ks_idx;
  logic [47:0] s3_ks_subkey, s3_f_key_dat;
  logic [31:0] s3_f_r_dat, s3_f_out;
  logic [31:0] s3_pipe [3];

  logic [47:0] subkeys [16];
  logic [3:0]  idx_log [256];
  vec_t        vecs [8];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  des_iter_ctrl u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .ks_idx(ks_idx), .ks_subkey(ks_subkey), .f_r_dat(f_r_dat),
    .f_key_dat(f_key_dat), .f_out(f_out)
  );

  des_iter_ctrl #(.F_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(s3_in_valid), .in_ready(s3_in_ready), .in_data(s3_in_data),
    .in_decrypt(s3_in_decrypt), .out_valid(s3_out_valid), .out_ready(s3_out_ready),
    .out_data(s3_out_data), .busy(s3_busy), .ks_idx(s3_ks_idx), .ks_subkey(s3_ks_subkey),
    .f_r_dat(s3_f_r_dat), .f_key_dat(s3_f_key_dat), .f_out(s3_f_out)
  );

  function automatic logic get_bit(input logic [63:0] v, input int w, input int pos);
    logic [63:0] t;
    t = v >> (w - pos);
    return t[0];
  endfunction

  function automatic logic [31:0] des_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] e, x;
    logic [31:0] s, p;
    logic [5:0]  six;
    e = '0;
    for (int i = 0; i < 48; i++) e = {e[46:0], get_bit({32'd0, r}, 32, E_T[i])};
    x = e ^ k;
    s = '0;
    for (int b = 0; b < 8; b++) begin
      six = 6'(x >> (42 - 6 * b));
      s = {s[27:0], SBOX[{b[2:0], six[5], six[0], six[4:1]}]};
    end
    p = '0;
    for (int i = 0; i < 32; i++) p = {p[30:0], get_bit({32'd0, s}, 32, P_T[i])};
    return p;
  endfunction

  // Round models: F_LAT register stages after the combinational f-function.
  always_ff @(posedge clk) f_pipe <= des_f(f_r_dat, f_key_dat);
  assign f_out = f_pipe;
  always_ff @(posedge clk) begin
    s3_pipe[0] <= des_f(s3_f_r_dat, s3_f_key_dat);
    s3_pipe[1] <= s3_pipe[0];
    s3_pipe[2] <= s3_pipe[1];
  end
  assign s3_f_out     = s3_pipe[2];
  assign ks_subkey    = subkeys[ks_idx];
  assign s3_ks_subkey = subkeys[s3_ks_idx];

  task automatic make_keys(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] sk;
    cd = '0;
    for (int i = 0; i < 56; i++) cd = {cd[54:0], get_bit(key, 64, PC1_T[i])};
    c = cd[55:28];
    d = cd[27:0];
    for (int rd = 0; rd < 16; rd++) begin
      for (int s = 0; s < SHIFTS[rd]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      sk = '0;
      for (int i = 0; i < 48; i++) sk = {sk[46:0], get_bit({8'd0, c, d}, 56, PC2_T[i])};
      subkeys[rd] = sk;
    end
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_accept(input string nm);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, " accept"}, in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_result(output int lat, output logic [63:0] d);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      idx_log[lat] = ks_idx;
      lat++;
      @(negedge clk);
    end
    d = out_data;
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int          lat, exp_idx;
    logic [63:0] d;
    logic        idx_ok;
    make_keys(v.key);
    in_data    = v.din;
    in_decrypt = v.dec;
    in_valid   = 1'b1;
    wait_accept(nm);
    in_valid = 1'b0;
    wait_result(lat, d);
    check({nm, " data"}, d, v.exp);
    check({nm, " latency"}, 64'(lat), 64'd32);
    idx_ok = 1'b1;
    for (int k = 0; k < 32; k++) begin
      exp_idx = v.dec ? 15 - k / 2 : k / 2;
      if (idx_log[k] !== exp_idx[3:0]) idx_ok = 1'b0;
    end
    check({nm, " ks_idx sequence"}, idx_ok, 1'b1);
    take_result();
    check({nm, " release valid/busy/ready"}, {out_valid, busy, in_ready}, 3'b001);
  endtask

  task automatic run3(input logic [63:0] din, input logic dec, input logic [63:0] exp,
                      input string nm);
    int          n, lat;
    logic [31:0] r0;
    logic [47:0] k0;
    logic        stab_ok;
    s3_in_data    = din;
    s3_in_decrypt = dec;
    s3_in_valid   = 1'b1;
    n = 0;
    while (s3_in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    s3_in_valid = 1'b0;
    lat = 0;
    stab_ok = 1'b1;
    r0 = '0;
    k0 = '0;
    while (s3_out_valid !== 1'b1 && lat < 400) begin
      if (lat % 4 == 0) begin
        r0 = s3_f_r_dat;
        k0 = s3_f_key_dat;
      end else if (s3_f_r_dat !== r0 || s3_f_key_dat !== k0) begin
        stab_ok = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    check({nm, " data"}, s3_out_data, exp);
    check({nm, " latency"}, 64'(lat), 64'd64);
    check({nm, " round inputs stable"}, stab_ok, 1'b1);
    s3_out_ready = 1'b1;
    @(negedge clk);
    s3_out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          lat, na, nh;
    int          acc [2];
    int          hs [2];
    logic [63:0] hd [2];
    logic [63:0] d;
    logic        ok, sw;

    vecs[0] = '{K1, PT, 1'b0, CT};
    vecs[1] = '{K1, CT, 1'b1, PT};
    vecs[2] = '{64'h0E329232EA6D0D73, 64'h8787878787878787, 1'b0, 64'h0000000000000000};
    vecs[3] = '{64'h0E329232EA6D0D73, 64'h0000000000000000, 1'b1, 64'h8787878787878787};
    vecs[4] = '{64'h0123456789ABCDEF, 64'h4E6F772069732074, 1'b0, 64'h3FA40E8A984D4815};
    vecs[5] = '{64'h0000000000000000, 64'h0000000000000000, 1'b0, 64'h8CA64DE9C1B123A7};
    vecs[6] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h7359B2163E4EDC58};
    vecs[7] = '{64'hFFFFFFFFFFFFFFFF, 64'h7359B2163E4EDC58, 1'b1, 64'hFFFFFFFFFFFFFFFF};

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_decrypt = 1'b0; out_ready = 1'b0;
    s3_in_valid = 1'b0; s3_in_data = '0; s3_in_decrypt = 1'b0; s3_out_ready = 1'b0;
    make_keys(K1);
    repeat (3) @(negedge clk);

    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset out_data", out_data, 64'd0);
    check("reset ks_idx", ks_idx, 4'd0);
    check("reset f_r_dat", f_r_dat, 32'd0);
    check("reset f_key_dat", f_key_dat, 48'd0);
    check("reset flat3 in_ready", s3_in_ready, 1'b1);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // Backpressure: result must hold while a second request is ignored.
    make_keys(K1);
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1;
    wait_accept("bp");
    in_valid = 1'b0;
    wait_result(lat, d);
    check("bp data", d, CT);
    in_data = CT; in_decrypt = 1'b1; in_valid = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== 1'b1 || out_data !== CT || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
      @(negedge clk);
    end
    check("bp hold", ok, 1'b1);
    take_result();
    check("bp released valid/ready", {out_valid, in_ready}, 2'b01);
    @(negedge clk);
    check("bp second accepted busy/ready", {busy, in_ready}, 2'b10);
    in_valid = 1'b0;
    wait_result(lat, d);
    check("bp second data", d, PT);
    check("bp second latency", 64'(lat), 64'd32);
    take_result();

    // Reset in round 7 aborts the block.
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1;
    wait_accept("mid");
    in_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("mid round7 ks_idx", ks_idx, 4'd7);
    rst = 1'b1;
    #1;
    check("mid reset valid/busy/ready", {out_valid, busy, in_ready}, 3'b001);
    @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0) ok = 1'b0;
      @(negedge clk);
    end
    check("mid no partial result", ok, 1'b1);
    run_vec(vecs[0], "mid fresh");

    // Back-to-back with in_valid held and out_ready tied high.
    make_keys(K1);
    na = 0; nh = 0; sw = 1'b0;
    acc[0] = -1; acc[1] = -1; hs[0] = -1; hs[1] = -1; hd[0] = '0; hd[1] = '0;
    in_data = PT; in_decrypt = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int n = 0; n < 200 && nh < 2; n++) begin
      if (na == 1 && !sw) begin
        in_data = CT;
        in_decrypt = 1'b1;
        sw = 1'b1;
      end
      if (na == 2) in_valid = 1'b0;
      if (in_valid && in_ready && na < 2) begin
        acc[na] = cyc + 1;
        na++;
      end
      if (out_valid && out_ready && nh < 2) begin
        hs[nh] = cyc + 1;
        hd[nh] = out_data;
        nh++;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("b2b first data", hd[0], CT);
    check("b2b second data", hd[1], PT);
    check("b2b accept-to-handshake", 64'(hs[0] - acc[0]), 64'd33);
    check("b2b re-accept gap", 64'(acc[1] - hs[0]), 64'd1);

    // F_LAT=3 build.
    make_keys(K1);
    run3(PT, 1'b0, CT, "flat3 enc");
    run3(CT, 1'b1, PT, "flat3 dec");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/des_iter_ctrl.md
Name: des_iter_ctrl

Overview:
- Iterative DES block controller that sequences one shared `Round` f-function instance (inputs `R_dat`[31:0] and `key_dat`[47:0], output `f_out`[31:0], clocked by clk) through 16 Feistel rounds.
- Accepts a 64-bit block and an encrypt/decrypt flag over a valid/ready handshake, and applies IP.
- Requests one subkey per round from an external key-schedule store by index, and performs the L/R XOR-and-swap.
- Applies FP and presents the 64-bit result over a valid/ready output handshake.

Parameters:
- F_LAT, 1, clock cycles from stable `R_dat`/`key_dat` at the `Round` inputs to valid `f_out` (range 0..7).
- NROUNDS, 16, number of Feistel rounds. Fixed for DES; parameterised only for reduced-round test builds.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  controller can accept a block.
- in_data  in  64  plaintext/ciphertext block, bit 63 = DES bit 1.
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled with in_data.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  64  result block after FP.
- busy  out  1  high from accept until the result is taken.
- ks_idx  out  4  subkey index requested from the key schedule.
- ks_subkey  in  48  subkey for ks_idx; combinational lookup, valid in the same cycle.
- f_r_dat  out  32  drives `Round` `R_dat`.
- f_key_dat  out  48  drives `Round` `key_dat`.
- f_out  in  32  from `Round` `f_out`.

Behaviour:
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, ks_idx=0, f_r_dat=0, f_key_dat=0. State=IDLE, L=R=0, rnd=0, wcnt=0.
- Reset asserted mid-operation aborts the block; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: {L,R}<=IP(in_data); dec<=in_decrypt; rnd<=0; wcnt<=0; go to RUN.
- RUN:
  - in_ready=0; busy=1.
  - ks_idx = dec ? (15-rnd) : rnd.
  - f_r_dat=R and f_key_dat=ks_subkey, combinational from registers. Both are held stable for the whole round.
  - wcnt counts 0..F_LAT. When wcnt==F_LAT: L<=R; R<=L^f_out; wcnt<=0; rnd<=rnd+1.
  - When updating with rnd==NROUNDS-1: out_data<=FP({R^... new R, new L}), i.e. the preoutput is the R16||L16 swap. Set out_valid<=1 and go to DONE.
- Round duration is F_LAT+1 cycles. Accept-to-out_valid latency is NROUNDS*(F_LAT+1) cycles; with defaults that is 32.
- DONE:
  - out_valid held with out_data stable until out_ready is sampled high.
  - On that edge: out_valid<=0, busy<=0, go to IDLE.
  - in_ready=0 throughout DONE. A new block is accepted at the earliest one cycle after the handshake.
- in_valid while not in IDLE is ignored; the upstream must hold it until accepted.
- out_ready while out_valid=0 has no effect.
- ks_idx wraps only through the rnd reset to 0 at accept. rnd never exceeds NROUNDS-1 in RUN.
- All XORs are 32-bit, no carries. Widths are exact; no truncation occurs.

Decomposition:
- Shared package des_pkg holds:
  - IP and FP bit-index constant tables, plus functions des_ip(64)->64 and des_fp(64)->64.
  - State encoding constants.
  - Width constants: 32, 48, 64.
- One natural sub-module: des_perm64, a generic combinational 64-bit permutation driven by a table parameter, instantiated twice (IP, FP).
- The `Round` instance lives outside this block, one level up. Only the controller is in scope here.

Test Plan:
- Encrypt: key 133457799BBCDFF1 with subkeys from the bench key-schedule model, in_data 0123456789ABCDEF, in_decrypt=0 -> out_data 85E813540F0AB405, out_valid 32 cycles after accept.
- Decrypt: same key, in_data 85E813540F0AB405, in_decrypt=1 -> out_data 0123456789ABCDEF; ks_idx sequence observed as 15,14,...,0, each held 2 cycles.
- Backpressure: out_ready held 0 for 20 cycles after out_valid -> out_valid and out_data stable, in_ready=0, a second in_valid is ignored; accepted 1 cycle after release.
- Reset mid-run: assert rst at round 7 -> next cycle out_valid=0, busy=0, in_ready=1. A fresh 0123456789ABCDEF encrypt then yields 85E813540F0AB405.
- F_LAT=3 build: same encrypt vector -> identical result with latency 64 cycles; f_r_dat/f_key_dat unchanged for 4 cycles per round.
- Back-to-back: two blocks with in_valid held high and out_ready tied 1 -> both results correct, second accept exactly 1 cycle after the first out handshake.
